sobel_ctrl: RTL

Bus-slave control/status block between the UDM debug bus master and the HLS Sobel core's `ap_ctrl_hs` port. It decodes a small CSR window on the UDM bus and runs the start/ready/done handshake with the core. It measures run time in clock cycles, counts completed runs and enforces an optional watchdog that resets a hung core. The host starts a frame, polls status and reads statistics through UDM writes and reads.

---
 rtl/sobel_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_ctrl.sv
// sobel_ctrl: UDM CSR slave driving the Sobel core ap_ctrl_hs handshake.
// Times each run, counts completions and resets a hung core via watchdog.
module sobel_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h00000020,
  parameter int unsigned RST_PULSE_LEN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        ap_start_o,
  output logic        ap_rst_o,
  input  logic        ap_done_i,
  input  logic        ap_ready_i,
  input  logic        ap_idle_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_FIN
  } state_t;

  localparam logic [3:0] PULSE = 4'(RST_PULSE_LEN);

  state_t      state_q;
  logic        ap_start_q;
  logic [31:0] cnt_q;
  logic [31:0] cycles_q;
  logic [31:0] runs_q;
  logic [31:0] timeout_q;
  logic        done_q;
  logic        err_q;
  logic        tmo_q;
  logic [3:0]  rst_cnt_q;
  logic        resp_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  logic        hit;
  logic [2:0]  off;
  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_runs;
  logic        wr_tmo;
  logic        soft_rst;
  logic        start_req;
  logic        start_ok;
  logic        start_err;
  logic        busy;
  logic        run;
  logic        fin_go;
  logic        wdt;
  logic [31:0] cnt_inc;
  logic        unused_addr;

  assign unused_addr = ^bus_addr_bi[1:0];

  assign hit = bus_addr_bi[31:5] == BASE_ADDR[31:5];
  assign off = bus_addr_bi[4:2];
  assign wr  = bus_req_i & bus_we_i & hit;
  assign rd  = bus_req_i & ~bus_we_i & hit;

  assign wr_ctrl = wr & (off == 3'd0);
  assign wr_stat = wr & (off == 3'd1);
  assign wr_runs = wr & (off == 3'd3);
  assign wr_tmo  = wr & (off == 3'd4);

  assign soft_rst  = wr_ctrl & bus_wdata_bi[1];
  assign start_req = wr_ctrl & bus_wdata_bi[0];
  assign start_ok  = start_req & ~soft_rst
                   & (state_q == S_IDLE)
                   & (rst_cnt_q == 4'd0);
  assign start_err = start_req & ~start_ok;

  assign busy = state_q != S_IDLE;
  assign run  = (state_q == S_ARM) | (state_q == S_WAIT);

  // A done that will be taken this cycle beats a simultaneous expiry.
  assign fin_go = ((state_q == S_ARM) & ap_ready_i & ap_done_i)
                | ((state_q == S_WAIT) & ap_done_i);
  assign wdt = run & (timeout_q != 32'd0)
             & (cnt_q == timeout_q) & ~fin_go;

  assign cnt_inc = (cnt_q == 32'hFFFFFFFF) ? cnt_q : cnt_q + 32'd1;

  assign bus_ack_o    = bus_req_i;
  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign ap_start_o   = ap_start_q;
  assign ap_rst_o     = rst_cnt_q != 4'd0;

  // Handshake FSM with run-time counter and registered ap_start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ap_start_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else if (soft_rst) begin
      state_q    <= S_IDLE;
      ap_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            cnt_q      <= 32'd0;
            state_q    <= S_ARM;
            ap_start_q <= 1'b1;
          end
        end
        S_ARM: begin
          cnt_q <= cnt_inc;
          if (fin_go) begin
            state_q    <= S_FIN;
            ap_start_q <= 1'b0;
          end else if (wdt) begin
            state_q    <= S_IDLE;
            ap_start_q <= 1'b0;
          end else if (ap_ready_i) begin
            state_q    <= S_WAIT;
            ap_start_q <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_inc;
          if (fin_go) begin
            state_q <= S_FIN;
          end else if (wdt) begin
            state_q <= S_IDLE;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          ap_start_q <= 1'b0;
        end
      endcase
    end
  end

  // CSR state: statistics, sticky flags (set beats clear), timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q  <= 32'd0;
      runs_q    <= 32'd0;
      timeout_q <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      if ((state_q == S_FIN) | wdt) begin
        cycles_q <= cnt_q;
      end
      if (wr_runs) begin
        runs_q <= 32'd0;
      end else if (state_q == S_FIN) begin
        runs_q <= runs_q + 32'd1;
      end
      if (state_q == S_FIN) begin
        done_q <= 1'b1;
      end else if (wr_stat & bus_wdata_bi[1]) begin
        done_q <= 1'b0;
      end
      if (start_err) begin
        err_q <= 1'b1;
      end else if (wr_stat & bus_wdata_bi[3]) begin
        err_q <= 1'b0;
      end
      if (wdt) begin
        tmo_q <= 1'b1;
      end else if (wr_stat & bus_wdata_bi[4]) begin
        tmo_q <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (wr_tmo & bus_be_bi[i]) begin
          timeout_q[8*i +: 8] <= bus_wdata_bi[8*i +: 8];
        end
      end
    end
  end

  // Core reset pulse; any new trigger restarts the full length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_cnt_q <= PULSE;
    end else if (soft_rst | wdt) begin
      rst_cnt_q <= PULSE;
    end else if (rst_cnt_q != 4'd0) begin
      rst_cnt_q <= rst_cnt_q - 4'd1;
    end
  end

  // Read data mux for the addressed CSR.
  always_comb begin
    rdata_d = 32'd0;
    case (off)
      3'd0: rdata_d = {31'd0, busy};
      3'd1: rdata_d = {27'd0, tmo_q, err_q, ap_idle_i, done_q, busy};
      3'd2: rdata_d = cycles_q;
      3'd3: rdata_d = runs_q;
      3'd4: rdata_d = timeout_q;
      default: rdata_d = 32'd0;
    endcase
  end

  // One-cycle registered read response for in-window reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      resp_q  <= rd;
      rdata_q <= rd ? rdata_d : 32'd0;
    end
  end

endmodule
